mul_operand_sequencer: RTL

Upstream feeder for the shift-add multiplier, which has a Start/Ready/Done interface. It accepts operand pairs through a valid/ready stream into a small FIFO and issues them to the multiplier one at a time. Operands are held stable for the whole multiplication. Each product is captured into a single-entry result register that has its own valid/ready output handshake.

---
 rtl/mul_operand_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer: operand FIFO feeding the Start/Ready/Done shift-add multiplier, with a registered result handshake
// Define MUL_SEQ_ZERO_BYPASS_EN to answer zero-operand pairs with 0 directly, without starting the multiplier.
module mul_operand_sequencer #(
    parameter int L_word = 4,
    parameter int DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [L_word-1:0]     in_word1,
    input  logic [L_word-1:0]     in_word2,
    output logic [L_word-1:0]     mul_word1,
    output logic [L_word-1:0]     mul_word2,
    output logic                  mul_start,
    input  logic                  mul_ready,
    input  logic                  mul_done,
    input  logic [2*L_word-1:0]   mul_product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*L_word-1:0]   out_product
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, ARM, BUSY} state_t;

    state_t                state_q, state_d;
    logic [L_word-1:0]     fifo1_q [DEPTH];
    logic [L_word-1:0]     fifo2_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [L_word-1:0]     op_word1_q, op_word1_d, op_word2_q, op_word2_d;
    logic                  out_valid_q, out_valid_d;
    logic [2*L_word-1:0]   out_product_q, out_product_d;
    logic                  full, empty, push, pop;

    assign full        = count_q == (AW+1)'(DEPTH);
    assign empty       = count_q == '0;
    assign in_ready    = !full;
    assign push        = in_valid && !full;
    assign pop         = state_q == IDLE && !empty && !out_valid_q;
    assign mul_word1   = op_word1_q;
    assign mul_word2   = op_word2_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;

    always_comb begin
        state_d       = state_q;
        op_word1_d    = op_word1_q;
        op_word2_d    = op_word2_q;
        out_valid_d   = out_valid_q && !out_ready;
        out_product_d = out_product_q;
        mul_start     = 1'b0;
        wr_ptr_d      = wr_ptr_q + AW'(push);
        rd_ptr_d      = rd_ptr_q + AW'(pop);
        count_d       = count_q + (AW+1)'(push) - (AW+1)'(pop);
        case (state_q)
            IDLE: if (pop) begin
`ifdef MUL_SEQ_ZERO_BYPASS_EN
                if (fifo1_q[rd_ptr_q] == '0 || fifo2_q[rd_ptr_q] == '0) begin
                    out_product_d = '0;
                    out_valid_d   = 1'b1;
                end else begin
                    op_word1_d = fifo1_q[rd_ptr_q];
                    op_word2_d = fifo2_q[rd_ptr_q];
                    state_d    = ISSUE;
                end
`else
                op_word1_d = fifo1_q[rd_ptr_q];
                op_word2_d = fifo2_q[rd_ptr_q];
                state_d    = ISSUE;
`endif
            end
            ISSUE: begin
                mul_start = mul_ready;
                state_d   = mul_ready ? ARM : ISSUE;
            end
            // Done is still high from the previous product here; it is not trusted until BUSY.
            ARM: state_d = BUSY;
            BUSY: if (mul_done) begin
                out_product_d = mul_product;
                out_valid_d   = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            op_word1_q    <= '0;
            op_word2_q    <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            op_word1_q    <= op_word1_d;
            op_word2_q    <= op_word2_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo1_q[wr_ptr_q] <= in_word1;
            fifo2_q[wr_ptr_q] <= in_word2;
        end
    end
endmodule
